// File: rtl/shift_add_seq.sv
// Sequential signed multiplier: data_in * weight[in_ch] by adding up to DEPTH
// nearest-power-of-two terms, with a one-cycle full multiply for any remainder.
module shift_add_seq #(
    parameter int unsigned BITS  = 17,
    parameter int unsigned NFRAC = 8,
    parameter int unsigned DEPTH = 3,
    parameter int unsigned NCH   = 4,
    localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     w_we,
    input  logic [CW-1:0]            w_addr,
    input  logic signed [BITS-1:0]   w_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CW-1:0]            in_ch,
    input  logic signed [BITS-1:0]   data_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [2*BITS-1:0] data_out,
    output logic signed [BITS-1:0]   data_q,
    output logic                     out_sat,
    output logic                     out_cplx
);

    localparam int unsigned W2   = 2 * BITS;
    localparam int unsigned KW   = $clog2(BITS);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    localparam logic signed [W2-1:0] QMax = {{(BITS + 1){1'b0}}, {(BITS - 1){1'b1}}};
    localparam logic signed [W2-1:0] QMin = {{(BITS + 1){1'b1}}, {(BITS - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StTerm, StFix, StDone} state_e;

    state_e                 state_q, state_d;
    logic signed [BITS-1:0] weights_q [NCH];
    logic signed [BITS-1:0] weights_d [NCH];
    logic signed [BITS-1:0] x_q, x_d;
    logic signed [BITS-1:0] r_q, r_d;
    logic signed [W2-1:0]   acc_q, acc_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   cplx_q, cplx_d;

    logic [BITS-1:0]        r_abs;
    logic [KW-1:0]          msb;
    logic                   half;
    logic [KW-1:0]          k_sel;
    logic signed [BITS:0]   pow2;
    logic signed [BITS:0]   r_wide;
    logic signed [W2-1:0]   x_ext, r_ext, x_shl, x_mul, acc_shr;

    // Weight bank next state; out-of-range addresses are dropped.
    always_comb begin
        weights_d = weights_q;
        if (w_we && (32'(w_addr) < NCH)) begin
            weights_d[w_addr] = w_data;
        end
    end

    // Nearest power of two to |r|; rounding up when the bit below the MSB is set
    // also sends exact midpoints to the larger exponent.
    always_comb begin
        r_abs = r_q[BITS-1] ? (~r_q + 1'b1) : r_q;
        msb   = '0;
        half  = 1'b0;
        for (int i = 1; i < BITS; i++) begin
            if (r_abs[i]) begin
                msb  = KW'(i);
                half = r_abs[i-1];
            end
        end
        k_sel = (half && (msb != KW'(BITS - 1))) ? msb + 1'b1 : msb;
        pow2        = '0;
        pow2[k_sel] = 1'b1;
        x_ext = {{BITS{x_q[BITS-1]}}, x_q};
        r_ext = {{BITS{r_q[BITS-1]}}, r_q};
        x_shl = x_ext <<< k_sel;
        x_mul = x_ext * r_ext;
    end

    // FSM next state and datapath updates.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        r_d     = r_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        cplx_d  = cplx_q;
        r_wide  = '0;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    x_d     = data_in;
                    r_d     = (32'(in_ch) < NCH) ? weights_q[in_ch] : '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                    cplx_d  = 1'b0;
                    state_d = StTerm;
                end
            end
            StTerm: begin
                if (r_q == '0) begin
                    state_d = StDone;
                end else begin
                    // Remainder widened by one bit so 2^(BITS-1) is representable.
                    r_wide = {r_q[BITS-1], r_q};
                    if (!r_q[BITS-1]) begin
                        acc_d  = acc_q + x_shl;
                        r_wide = r_wide - pow2;
                    end else begin
                        acc_d  = acc_q - x_shl;
                        r_wide = r_wide + pow2;
                    end
                    r_d   = r_wide[BITS-1:0];
                    cnt_d = cnt_q + 1'b1;
                    if (r_wide == '0) begin
                        state_d = StDone;
                    end else if (cnt_d == CntW'(DEPTH)) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                acc_d   = acc_q + x_mul;
                cplx_d  = 1'b1;
                state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake flags and scaled, saturated output.
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        data_out  = acc_q;
        out_cplx  = cplx_q;
        acc_shr   = acc_q >>> NFRAC;
        out_sat   = 1'b0;
        data_q    = acc_shr[BITS-1:0];
        if (acc_shr > QMax) begin
            data_q  = QMax[BITS-1:0];
            out_sat = 1'b1;
        end else if (acc_shr < QMin) begin
            data_q  = QMin[BITS-1:0];
            out_sat = 1'b1;
        end
    end

    // State registers with synchronous reset that also wins over weight writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            x_q     <= '0;
            r_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            cplx_q  <= 1'b0;
            for (int i = 0; i < int'(NCH); i++) begin
                weights_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            r_q       <= r_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            cplx_q    <= cplx_d;
            weights_q <= weights_d;
        end
    end

endmodule

// File: tb/tb_shift_add_seq.sv
// Bench for shift_add_seq: product/latency model from the arithmetic rules,
// per-cycle compare at negedge, directed literal cases, then random traffic.
module tb_shift_add_seq;

    localparam int BITS  = 17;
    localparam int NFRAC = 8;
    localparam int DEPTH = 3;
    localparam int NCH   = 4;
    localparam int CW    = 2;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     w_we = 1'b0;
    logic [CW-1:0]            w_addr = '0;
    logic signed [BITS-1:0]   w_data = '0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic [CW-1:0]            in_ch = '0;
    logic signed [BITS-1:0]   data_in = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [2*BITS-1:0] data_out;
    logic signed [BITS-1:0]   data_q;
    logic                     out_sat;
    logic                     out_cplx;

    shift_add_seq #(
        .BITS (BITS),
        .NFRAC(NFRAC),
        .DEPTH(DEPTH),
        .NCH  (NCH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .w_we     (w_we),
        .w_addr   (w_addr),
        .w_data   (w_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_ch    (in_ch),
        .data_in  (data_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .data_out (data_out),
        .data_q   (data_q),
        .out_sat  (out_sat),
        .out_cplx (out_cplx)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference: product is x*w; term count follows the nearest-power-of-two rule.
    function automatic void model_op(input longint x, input longint w, output longint prod,
                                     output longint q, output bit sat, output bit cplx,
                                     output int lat);
        longint r, a, d, bestd;
        int     t, bestk;
        prod = x * w;
        r    = w;
        t    = 0;
        while (r != 0 && t < DEPTH) begin
            a     = (r < 0) ? -r : r;
            bestd = 64'h7fff_ffff_ffff_ffff;
            bestk = 0;
            for (int k = 0; k < BITS; k++) begin
                d = a - (longint'(1) << k);
                if (d < 0) d = -d;
                if (d <= bestd) begin
                    bestd = d;
                    bestk = k;
                end
            end
            if (r > 0) r = r - (longint'(1) << bestk);
            else       r = r + (longint'(1) << bestk);
            t++;
        end
        cplx = (r != 0);
        lat  = 1 + ((t == 0) ? 1 : t) + (cplx ? 1 : 0);
        q    = prod >>> NFRAC;
        sat  = 1'b0;
        if (q > (longint'(1) << (BITS - 1)) - 1) begin
            q   = (longint'(1) << (BITS - 1)) - 1;
            sat = 1'b1;
        end else if (q < -(longint'(1) << (BITS - 1))) begin
            q   = -(longint'(1) << (BITS - 1));
            sat = 1'b1;
        end
    endfunction

    longint weights_m [NCH];
    bit     m_busy = 1'b0;
    bit     m_valid = 1'b0;
    int     m_cnt = 0;
    longint e_prod, e_q;
    bit     e_sat, e_cplx;
    int     e_lat;

    // Model advances on each rising edge using the inputs seen at that edge.
    initial forever begin
        @(posedge clk);
        if (reset) begin
            for (int k = 0; k < NCH; k++) weights_m[k] = 0;
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_cnt   = 0;
        end else begin
            if (m_valid) begin
                if (out_ready) begin
                    m_valid = 1'b0;
                    m_busy  = 1'b0;
                end
            end else if (m_busy) begin
                m_cnt--;
                if (m_cnt == 0) m_valid = 1'b1;
            end else if (in_valid) begin
                model_op(longint'(data_in), (int'(in_ch) < NCH) ? weights_m[in_ch] : 0,
                         e_prod, e_q, e_sat, e_cplx, e_lat);
                m_busy = 1'b1;
                m_cnt  = e_lat - 1;
            end
            if (w_we && int'(w_addr) < NCH) weights_m[w_addr] = longint'(w_data);
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("in_ready", in_ready, !m_busy);
            check("out_valid", out_valid, m_valid);
            if (m_valid) begin
                check("data_out", data_out, e_prod);
                check("data_q", data_q, e_q);
                check("out_sat", out_sat, e_sat);
                check("out_cplx", out_cplx, e_cplx);
            end
        end
    end

    longint last_prod, last_q;
    bit     last_sat, last_cplx;
    int     last_lat;

    task automatic rnd_write(input bit en);
        w_we   = en && ($urandom_range(0, 3) == 0);
        w_addr = CW'($urandom_range(0, NCH - 1));
        w_data = BITS'($urandom_range(0, 131071));
    endtask

    task automatic write_w(input int addr, input int val);
        @(posedge clk); #1;
        w_we   = 1'b1;
        w_addr = CW'(addr);
        w_data = BITS'(val);
        @(posedge clk); #1;
        w_we   = 1'b0;
    endtask

    // One transaction; optional weight write in the accept cycle, optional
    // random writes while in flight, out_ready held low for 'hold' cycles.
    task automatic run_op(input int ch, input int data, input int hold, input bit wr,
                          input int waddr, input int wdata, input bit rnd);
        logic signed [2*BITS-1:0] cap;
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_ch    = CW'(ch);
        data_in  = BITS'(data);
        w_we     = wr;
        w_addr   = CW'(waddr);
        w_data   = BITS'(wdata);
        @(posedge clk); #1;
        in_valid = 1'b0;
        last_lat = 1;
        rnd_write(rnd);
        while (!out_valid && last_lat < 20) begin
            @(posedge clk); #1;
            last_lat++;
            rnd_write(rnd);
        end
        check("out_valid_timeout", out_valid, 1);
        last_prod = longint'(data_out);
        last_q    = longint'(data_q);
        last_sat  = out_sat;
        last_cplx = out_cplx;
        cap       = data_out;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            rnd_write(rnd);
            check("hold_data_out", data_out, cap);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        w_we      = 1'b0;
    endtask

    int seen;
    int tbl [6] = '{0, 1, -1, 65535, -65536, 85};

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_data_q", data_q, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_out_cplx", out_cplx, 0);

        write_w(0, 5);
        write_w(1, -5);
        write_w(2, 0);
        write_w(3, 85);

        run_op(0, 3, 0, 1'b0, 0, 0, 1'b0);
        check("w5_prod", last_prod, 15);
        check("w5_q", last_q, 0);
        check("w5_cplx", last_cplx, 0);
        check("w5_lat", last_lat, 3);

        run_op(1, 7, 0, 1'b0, 0, 0, 1'b0);
        check("wm5_prod", last_prod, -35);
        check("wm5_lat", last_lat, 3);

        run_op(2, 1234, 0, 1'b0, 0, 0, 1'b0);
        check("w0_prod", last_prod, 0);
        check("w0_lat", last_lat, 2);

        run_op(3, 2, 0, 1'b0, 0, 0, 1'b0);
        check("w85_prod", last_prod, 170);
        check("w85_cplx", last_cplx, 1);
        check("w85_lat", last_lat, 5);

        run_op(0, 1, 0, 1'b1, 0, 9, 1'b0);
        check("same_cycle_old_w", last_prod, 5);
        run_op(0, 1, 0, 1'b0, 0, 0, 1'b0);
        check("same_cycle_new_w", last_prod, 9);

        write_w(0, 65535);
        run_op(0, 65535, 5, 1'b0, 0, 0, 1'b0);
        check("big_prod", last_prod, 64'd4294836225);
        check("big_q", last_q, 65535);
        check("big_sat", last_sat, 1);
        check("big_lat", last_lat, 3);

        // Reset during the second TERM cycle of the w=85 operation.
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_ch    = 2'd3;
        data_in  = 17'sd2;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        seen  = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_valid_after_rst", seen, 0);
        check("ready_after_rst", in_ready, 1);
        for (int c = 0; c < NCH; c++) begin
            run_op(c, 1, 0, 1'b0, 0, 0, 1'b0);
            check("cleared_weight", last_prod, 0);
        end

        // Random traffic with edge-value weights/data mixed in.
        for (int n = 0; n < 200; n++) begin
            int d, wv;
            wv = ($urandom_range(0, 3) == 0) ? tbl[$urandom_range(0, 5)]
                                             : int'($urandom_range(0, 131071)) - 65536;
            d  = ($urandom_range(0, 3) == 0) ? tbl[$urandom_range(0, 5)]
                                             : int'($urandom_range(0, 131071)) - 65536;
            if ($urandom_range(0, 1) == 0) write_w(int'($urandom_range(0, NCH - 1)), wv);
            run_op(int'($urandom_range(0, NCH - 1)), d, int'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0), int'($urandom_range(0, NCH - 1)),
                   int'($urandom_range(0, 131071)) - 65536, 1'b1);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d",
                 n_chk, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
